udt_ctrl_dispatch: RTL and testbench
====================================

// Module: udt_ctrl_dispatch
// PURPOSE
//  Ingress stage ahead of the CLOSE/ACK/data handlers. Takes the 64-bit AXI-Stream of received
//  UDT packets and classifies each packet on its first beat. Routes SHUTDOWN control packets to
//  the close path, other known control packets to the ctrl path, and data packets to the data
//  path. Drops unknown control types. One registered output slice; full throughput.
// PARAMETERS
//  CLOSE_TYPE     5   control type routed to close_* (UDT shutdown)
//  MAX_CTRL_TYPE  7   highest legal control type; larger types are dropped
//  CNT_W          16  width of drop_cnt_o
// PORTS
//  core_clk        in   1      core clock; single clock domain
//  core_rst        in   1      synchronous active-high reset
//  rx_tvalid_i     in   1      ingress beat valid
//  rx_tdata_i      in   64     ingress data; first beat [63]=ctrl flag, [62:48]=type
//  rx_tkeep_i      in   8      ingress byte enables
//  rx_tlast_i      in   1      ingress last beat
//  rx_tready_o     out  1      ingress ready
//  close_tvalid_o/close_tdata_o[63:0]/close_tkeep_o[7:0]/close_tlast_o  out  shutdown packet stream
//  close_tready_i  in   1      close path ready
//  ctrl_tvalid_o/ctrl_tdata_o[63:0]/ctrl_tkeep_o[7:0]/ctrl_tlast_o      out  other control stream
//  ctrl_tready_i   in   1      ctrl path ready
//  data_tvalid_o/data_tdata_o[63:0]/data_tkeep_o[7:0]/data_tlast_o      out  data packet stream
//  data_tready_i   in   1      data path ready
//  close_seen_o    out  1      one-cycle pulse when a shutdown first beat is accepted
//  drop_cnt_o      out  CNT_W  count of dropped packets; saturates at all-ones
// BEHAVIOUR
//  - FSM states: SOP, FWD, DROP. Reset enters SOP.
//  - SOP: an accepted beat is classified.
//      - [63]=0 -> DATA.
//      - [63]=1 and type==CLOSE_TYPE -> CLOSE.
//      - [63]=1 and type<=MAX_CTRL_TYPE -> CTRL.
//      - Otherwise -> DROP.
//    A routed beat loads the output slice with sel=dest. Next state is FWD, or SOP if tlast.
//    A dropped beat is not loaded. Next state is DROP, or SOP if tlast; drop_cnt_o increments on
//    this classification beat.
//  - FWD: every accepted beat loads the slice with the latched sel. Accepting tlast returns to SOP.
//  - DROP: rx_tready_o=1. Beats are consumed and discarded. Accepting tlast returns to SOP.
//  - Slice: out_valid plus registered tdata/tkeep/tlast/sel. Only the selected port shows
//    tvalid=out_valid; the other two tvalid outputs are 0. sel_ready is the selected port's tready.
//  - rx_tready_o = (state==DROP) | ~out_valid | sel_ready.
//    Load and unload in the same cycle is allowed: no bubble.
//  - Latency: 1 cycle from ingress accept to egress valid. Beat order is preserved. Packets never
//    interleave across ports.
//  - Egress holds data stable while tvalid=1 and tready=0.
//  - close_seen_o is registered. It pulses the cycle after the CLOSE first beat is accepted,
//    aligned with close_tvalid_o first assertion.
//  - Reset values: all tvalid outputs 0; tdata/tkeep/tlast 0; close_seen_o 0; drop_cnt_o 0;
//    rx_tready_o 1.
//  - Reset mid-packet: the slice is flushed and the FSM goes to SOP. The remainder of the
//    interrupted packet is classified as a new packet.
//  - A single-beat packet (tlast on the first beat) routes and returns to SOP in one accept.
//  - tkeep is passed unmodified. tkeep=0 beats are forwarded and not filtered.
// TESTING
//  1. First beat 0x8005_0000_0000_0000, tlast=1, close ready -> close_tvalid_o=1 next cycle with
//     same data; close_seen_o pulses; ctrl/data valid stay 0.
//  2. 3-beat data packet ([63]=0), data_tready_i=1 -> 3 egress beats on data_*, back-to-back,
//     tlast on the 3rd.
//  3. Control type 9, 2 beats -> nothing on any egress; drop_cnt_o 0->1; rx_tready_o=1 throughout.
//  4. ACK (type 2) 4 beats with ctrl_tready_i toggling 1,0,1,0 -> no beat lost or duplicated;
//     data held while stalled.
//  5. Reset asserted after beat 2 of a 4-beat CTRL packet -> all tvalid 0 next cycle; beat 3
//     classified as a new packet.
//  6. drop_cnt_o preset to all-ones via 2^CNT_W drops (CNT_W=4 build) -> stays 0xF.

Source files
------------

// File: rtl/udt_ctrl_dispatch.sv
// udt_ctrl_dispatch
//   Ingress classifier that sits ahead of the CLOSE/ACK/data handlers. It
//   inspects the first beat of each received UDT packet and steers the whole
//   packet to one of three AXI-Stream egress ports:
//     close_*  control packets whose type equals CLOSE_TYPE (shutdown)
//     ctrl_*   other control packets with type <= MAX_CTRL_TYPE
//     data_*   data packets (first-beat bit 63 clear)
//   Control packets with an unknown type are consumed and counted.
//   A single registered output slice sits in front of all three ports. It
//   accepts a new beat while it unloads the old one, so throughput is one
//   beat per cycle.
// Ports
//   core_clk, core_rst        clock, synchronous active-high reset
//   rx_t*                     ingress stream (first beat: [63] ctrl flag,
//                             [62:48] control type)
//   close_t*/ctrl_t*/data_t*  egress streams
//   close_seen_o              one-cycle pulse that lines up with the first
//                             close_tvalid_o of a shutdown packet
//   drop_cnt_o                dropped-packet count, saturates at all-ones
module udt_ctrl_dispatch #(
  parameter int unsigned CLOSE_TYPE    = 5,
  parameter int unsigned MAX_CTRL_TYPE = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             rx_tvalid_i,
  input  logic [63:0]      rx_tdata_i,
  input  logic [7:0]       rx_tkeep_i,
  input  logic             rx_tlast_i,
  output logic             rx_tready_o,
  output logic             close_tvalid_o,
  output logic [63:0]      close_tdata_o,
  output logic [7:0]       close_tkeep_o,
  output logic             close_tlast_o,
  input  logic             close_tready_i,
  output logic             ctrl_tvalid_o,
  output logic [63:0]      ctrl_tdata_o,
  output logic [7:0]       ctrl_tkeep_o,
  output logic             ctrl_tlast_o,
  input  logic             ctrl_tready_i,
  output logic             data_tvalid_o,
  output logic [63:0]      data_tdata_o,
  output logic [7:0]       data_tkeep_o,
  output logic             data_tlast_o,
  input  logic             data_tready_i,
  output logic             close_seen_o,
  output logic [CNT_W-1:0] drop_cnt_o
);

  localparam logic [1:0] SOP  = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [1:0] SEL_CLOSE = 2'd0;
  localparam logic [1:0] SEL_CTRL  = 2'd1;
  localparam logic [1:0] SEL_DATA  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       fwd_sel;
  logic             out_valid;
  logic [63:0]      out_data;
  logic [7:0]       out_keep;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             close_seen;
  logic [CNT_W-1:0] drop_cnt;

  logic [14:0]      rx_type;
  logic [1:0]       route_sel;
  logic             route_drop;
  logic             sel_ready;
  logic             accept;
  logic             sop_accept;
  logic             load;
  logic [1:0]       load_sel;

  // First-beat classification; only meaningful while in SOP.
  always_comb begin
    rx_type    = rx_tdata_i[62:48];
    route_sel  = SEL_DATA;
    route_drop = 1'b0;
    if (rx_tdata_i[63]) begin
      if (rx_type == 15'(CLOSE_TYPE)) begin
        route_sel = SEL_CLOSE;
      end else if (rx_type <= 15'(MAX_CTRL_TYPE)) begin
        route_sel = SEL_CTRL;
      end else begin
        route_drop = 1'b1;
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    case (out_sel)
      SEL_CLOSE: sel_ready = close_tready_i;
      SEL_CTRL:  sel_ready = ctrl_tready_i;
      SEL_DATA:  sel_ready = data_tready_i;
      default:   sel_ready = 1'b0;
    endcase
  end

  // The slice may be refilled in the same cycle it drains; DROP never loads
  // the slice so it does not have to wait for the egress side.
  assign rx_tready_o = (state == DROP) | ~out_valid | sel_ready;
  assign accept      = rx_tvalid_i & rx_tready_o;
  assign sop_accept  = accept & (state == SOP);
  assign load        = accept & ((state == FWD) | ((state == SOP) & ~route_drop));
  assign load_sel    = (state == SOP) ? route_sel : fwd_sel;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state      <= SOP;
      fwd_sel    <= SEL_DATA;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_last   <= 1'b0;
      out_sel    <= SEL_CLOSE;
      close_seen <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= rx_tdata_i;
        out_keep  <= rx_tkeep_i;
        out_last  <= rx_tlast_i;
        out_sel   <= load_sel;
      end else if (sel_ready) begin
        out_valid <= 1'b0;
      end

      close_seen <= sop_accept & ~route_drop & (route_sel == SEL_CLOSE);

      if (sop_accept && route_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end

      case (state)
        SOP: begin
          if (accept && !rx_tlast_i) begin
            if (route_drop) begin
              state <= DROP;
            end else begin
              state   <= FWD;
              fwd_sel <= route_sel;
            end
          end
        end
        FWD, DROP: begin
          if (accept && rx_tlast_i) begin
            state <= SOP;
          end
        end
        default: state <= SOP;
      endcase
    end
  end

  assign close_tvalid_o = out_valid & (out_sel == SEL_CLOSE);
  assign ctrl_tvalid_o  = out_valid & (out_sel == SEL_CTRL);
  assign data_tvalid_o  = out_valid & (out_sel == SEL_DATA);

  assign close_tdata_o  = out_data;
  assign close_tkeep_o  = out_keep;
  assign close_tlast_o  = out_last;
  assign ctrl_tdata_o   = out_data;
  assign ctrl_tkeep_o   = out_keep;
  assign ctrl_tlast_o   = out_last;
  assign data_tdata_o   = out_data;
  assign data_tkeep_o   = out_keep;
  assign data_tlast_o   = out_last;

  assign close_seen_o   = close_seen;
  assign drop_cnt_o     = drop_cnt;

endmodule

// File: tb/tb_udt_ctrl_dispatch.sv
// tb_udt_ctrl_dispatch
//   Directed bench for udt_ctrl_dispatch, built with CNT_W=4 so the drop
//   counter can be driven into saturation with a short run.
module tb_udt_ctrl_dispatch;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_tvalid;
  logic [63:0]   rx_tdata;
  logic [7:0]    rx_tkeep;
  logic          rx_tlast;
  logic          rx_tready;
  logic          close_tvalid, ctrl_tvalid, data_tvalid;
  logic [63:0]   close_tdata, ctrl_tdata, data_tdata;
  logic [7:0]    close_tkeep, ctrl_tkeep, data_tkeep;
  logic          close_tlast, ctrl_tlast, data_tlast;
  logic          close_tready, ctrl_tready, data_tready;
  logic          close_seen;
  logic [CW-1:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  udt_ctrl_dispatch #(.CLOSE_TYPE(5), .MAX_CTRL_TYPE(7), .CNT_W(CW)) dut (
    .core_clk       (clk),
    .core_rst       (rst),
    .rx_tvalid_i    (rx_tvalid),
    .rx_tdata_i     (rx_tdata),
    .rx_tkeep_i     (rx_tkeep),
    .rx_tlast_i     (rx_tlast),
    .rx_tready_o    (rx_tready),
    .close_tvalid_o (close_tvalid),
    .close_tdata_o  (close_tdata),
    .close_tkeep_o  (close_tkeep),
    .close_tlast_o  (close_tlast),
    .close_tready_i (close_tready),
    .ctrl_tvalid_o  (ctrl_tvalid),
    .ctrl_tdata_o   (ctrl_tdata),
    .ctrl_tkeep_o   (ctrl_tkeep),
    .ctrl_tlast_o   (ctrl_tlast),
    .ctrl_tready_i  (ctrl_tready),
    .data_tvalid_o  (data_tvalid),
    .data_tdata_o   (data_tdata),
    .data_tkeep_o   (data_tkeep),
    .data_tlast_o   (data_tlast),
    .data_tready_i  (data_tready),
    .close_seen_o   (close_seen),
    .drop_cnt_o     (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k, input logic l);
    rx_tvalid = v;
    rx_tdata  = d;
    rx_tkeep  = k;
    rx_tlast  = l;
  endtask

  logic [63:0] ack [4];
  logic [63:0] prev_data;
  logic        prev_stall;
  logic        acc;
  int          si, rc;

  initial begin
    rst = 1'b1;
    close_tready = 1'b1;
    ctrl_tready  = 1'b1;
    data_tready  = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    tick();

    // Reset state
    check("rst_close_v", close_tvalid, 0);
    check("rst_ctrl_v", ctrl_tvalid, 0);
    check("rst_data_v", data_tvalid, 0);
    check("rst_tdata", data_tdata, 0);
    check("rst_tready", rx_tready, 1);
    check("rst_seen", close_seen, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: single-beat shutdown packet
    drive(1'b1, 64'h8005_0000_0000_0000, 8'hFF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t1_close_v", close_tvalid, 1);
    check("t1_close_d", close_tdata, 64'h8005_0000_0000_0000);
    check("t1_close_l", close_tlast, 1);
    check("t1_seen", close_seen, 1);
    check("t1_ctrl_v", ctrl_tvalid, 0);
    check("t1_data_v", data_tvalid, 0);
    tick();
    check("t1_seen_end", close_seen, 0);
    check("t1_close_end", close_tvalid, 0);

    // 2: 3-beat data packet, middle beat with tkeep=0
    drive(1'b1, 64'h0000_0000_0000_1111, 8'hFF, 1'b0);
    tick();
    check("t2_b0_v", data_tvalid, 1);
    check("t2_b0_d", data_tdata, 64'h0000_0000_0000_1111);
    check("t2_b0_l", data_tlast, 0);
    drive(1'b1, 64'h8009_0000_0000_2222, 8'h00, 1'b0);
    tick();
    check("t2_b1_v", data_tvalid, 1);
    check("t2_b1_d", data_tdata, 64'h8009_0000_0000_2222);
    check("t2_b1_k", data_tkeep, 0);
    check("t2_b1_ctrl_v", ctrl_tvalid, 0);
    drive(1'b1, 64'h0000_0000_0000_3333, 8'h0F, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t2_b2_v", data_tvalid, 1);
    check("t2_b2_d", data_tdata, 64'h0000_0000_0000_3333);
    check("t2_b2_k", data_tkeep, 8'h0F);
    check("t2_b2_l", data_tlast, 1);
    tick();
    check("t2_end_v", data_tvalid, 0);

    // 3: unknown control type 9, two beats, dropped
    drive(1'b1, 64'h8009_0000_0000_0000, 8'hFF, 1'b0);
    #1;
    check("t3_b0_rdy", rx_tready, 1);
    tick();
    check("t3_b0_any_v", {close_tvalid, ctrl_tvalid, data_tvalid}, 0);
    check("t3_drop1", drop_cnt, 1);
    drive(1'b1, 64'h0000_0000_0000_4444, 8'hFF, 1'b1);
    #1;
    check("t3_b1_rdy", rx_tready, 1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t3_b1_any_v", {close_tvalid, ctrl_tvalid, data_tvalid}, 0);
    check("t3_drop_hold", drop_cnt, 1);

    // 4: ACK (type 2), 4 beats, ctrl_tready toggling 1,0,1,0,...
    ack[0] = 64'h8002_0000_0000_A000;
    ack[1] = 64'h0000_0000_0000_A001;
    ack[2] = 64'h0000_0000_0000_A002;
    ack[3] = 64'h0000_0000_0000_A003;
    si = 0;
    rc = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 40 && rc < 4; cyc++) begin
      ctrl_tready = (cyc % 2) == 0;
      if (si < 4) drive(1'b1, ack[si], 8'hFF, si == 3);
      else        drive(1'b0, '0, '0, 1'b0);
      #1;
      acc = rx_tvalid & rx_tready;
      if (prev_stall) check("t4_hold", ctrl_tdata, prev_data);
      if (ctrl_tvalid && ctrl_tready) begin
        if (rc < 4) check($sformatf("t4_beat%0d", rc), ctrl_tdata, ack[rc]);
        rc++;
      end
      prev_stall = ctrl_tvalid & ~ctrl_tready;
      prev_data  = ctrl_tdata;
      tick();
      if (acc) si++;
    end
    check("t4_count", rc, 4);
    ctrl_tready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("t4_no_extra", ctrl_tvalid, 0);

    // 5: reset after beat 2 of a 4-beat CTRL packet
    drive(1'b1, 64'h8003_0000_0000_C000, 8'hFF, 1'b0);
    tick();
    drive(1'b1, 64'h0000_0000_0000_C001, 8'hFF, 1'b0);
    tick();
    check("t5_pre_ctrl_v", ctrl_tvalid, 1);
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_v", {close_tvalid, ctrl_tvalid, data_tvalid}, 0);
    drive(1'b1, 64'h0000_0000_0000_C002, 8'hFF, 1'b0);
    tick();
    check("t5_b2_data_v", data_tvalid, 1);
    check("t5_b2_ctrl_v", ctrl_tvalid, 0);
    check("t5_b2_d", data_tdata, 64'h0000_0000_0000_C002);
    drive(1'b1, 64'h0000_0000_0000_C003, 8'hFF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("t5_b3_l", data_tlast, 1);
    check("t5_drop_rst", drop_cnt, 0);
    tick();

    // Boundary: type 7 is the highest routed control type
    drive(1'b1, 64'h8007_0000_0000_0007, 8'hFF, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("b7_ctrl_v", ctrl_tvalid, 1);
    check("b7_seen", close_seen, 0);
    tick();

    // 6: type 8 single-beat drops until the counter saturates
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 64'h8008_0000_0000_0000, 8'hFF, 1'b1);
      tick();
      check($sformatf("t6_drop%0d", i), drop_cnt, (i < 15) ? i + 1 : 15);
    end
    drive(1'b0, '0, '0, 1'b0);
    check("t6_no_v", {close_tvalid, ctrl_tvalid, data_tvalid}, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
